// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a five-stage LEGv8 pipeline: stage enables,
// bubble/flush strobes, ALU forwarding selects, memory-wait freeze and perf counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       if_id_rn,
    input  logic [4:0]       if_id_rm,
    input  logic             if_id_uses_rm,
    input  logic [4:0]       id_ex_rn,
    input  logic [4:0]       id_ex_rm,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic [4:0]       ex_mem_rd,
    input  logic [4:0]       mem_wb_rd,
    input  logic             ex_mem_regwrite,
    input  logic             mem_wb_regwrite,
    input  logic             ex_mem_memaccess,
    input  logic             en_jump,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [4:0]        XZR       = 5'd31;

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_nxt;
    logic               r_release;
    logic               r_mem_error;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [CNT_W-1:0]   r_flush_events;

    logic               w_freeze;
    logic               w_timeout;
    logic               w_branch;
    logic               w_load_use;
    logic               w_lu_stall;

    // Forwarding select for one EX operand; EX/MEM result is younger so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       em_rw,
        input logic [4:0] em_rd,
        input logic       wb_rw,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (em_rw && (em_rd != XZR) && (em_rd == src)) begin
            sel = 2'b10;
        end else if (wb_rw && (wb_rd != XZR) && (wb_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // r_release makes the cycle after a timeout advance as though memory had answered.
    always_comb begin
        w_freeze  = 1'b0;
        w_timeout = 1'b0;
        if (r_state == StMemWait) begin
            w_freeze  = !mem_ready;
            w_timeout = !mem_ready && (r_wait_cnt == WAIT_LAST);
        end else begin
            w_freeze  = ex_mem_memaccess && !mem_ready && !r_release;
        end
    end

    assign w_branch   = en_jump && !w_freeze;
    assign w_load_use = id_ex_memread && (id_ex_rd != XZR) &&
                        ((id_ex_rd == if_id_rn) || (if_id_uses_rm && (id_ex_rd == if_id_rm)));
    assign w_lu_stall = w_load_use && !w_branch && !w_freeze;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun: begin
                if (w_freeze) begin
                    w_state_nxt = StMemWait;
                end
            end
            StMemWait: begin
                if (mem_ready || w_timeout) begin
                    w_state_nxt = StRun;
                end
            end
            default: w_state_nxt = StRun;
        endcase
    end

    assign w_wait_cnt_nxt = (w_freeze && !w_timeout) ? (r_wait_cnt + WAIT_W'(1)) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StRun;
            r_wait_cnt  <= '0;
            r_release   <= 1'b0;
            r_mem_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_release   <= w_timeout;
            r_mem_error <= r_mem_error || w_timeout;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if ((w_freeze || w_lu_stall) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_branch && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    // Priority: reset, freeze, branch, load-use.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!reset_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (w_branch) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_lu_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reset_n) begin
            fwd_a = fwd_sel(id_ex_rn, ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd);
            fwd_b = fwd_sel(id_ex_rm, ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd);
        end
    end

    assign mem_error    = r_mem_error;
    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule
